// File: rtl/bram_adder_arbiter_if.sv
// Request/response bundle between client logic and the shared A+B+1 adder.
// The slave side is the arbiter; the master side is the client/consumer.
interface bram_adder_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
);
  logic                   flush;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_carry;
  logic [TAG_W-1:0]       rsp_tag;
  logic                   busy;

  modport master (
    output flush, req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_tag, busy
  );

  modport slave (
    input  flush, req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_tag, busy
  );
endinterface

// File: rtl/bram_adder_arbiter.sv
// Round-robin arbiter sharing one registered A+B+1 adder across N_REQ requesters,
// followed by a LAT-deep tagged result pipeline with response backpressure.
module bram_adder_arbiter #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4,
  parameter int TAG_W = 2,
  parameter int LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bram_adder_arbiter_if.slave  bus
);

  logic [LAT-1:0]   stg_valid;
  logic [TAG_W-1:0] stg_tag [LAT];
  logic [WIDTH:0]   stg_res [LAT];

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] grant;
  logic [TAG_W-1:0] ptr_next;
  logic [TAG_W:0]   idx;
  logic             found;
  logic             advance;
  logic             xfer;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign advance = !stg_valid[LAT-1] || bus.rsp_ready;

  always_comb begin
    grant = ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + (TAG_W+1)'(i);
      if (idx >= (TAG_W+1)'(N_REQ)) idx = idx - (TAG_W+1)'(N_REQ);
      if (!found && bus.req_valid[idx[TAG_W-1:0]]) begin
        found = 1'b1;
        grant = idx[TAG_W-1:0];
      end
    end
  end

  // rst_n gating keeps req_ready low for the whole time reset is held.
  assign xfer = found && advance && !bus.flush && rst_n;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[grant] = 1'b1;
  end

  assign ptr_next = (grant == TAG_W'(N_REQ-1)) ? '0 : grant + TAG_W'(1);
  assign op_a     = bus.req_a[grant*WIDTH +: WIDTH];
  assign op_b     = bus.req_b[grant*WIDTH +: WIDTH];
  assign sum      = {1'b0, op_a} + {1'b0, op_b} + (WIDTH+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      ptr       <= '0;
      for (int s = 0; s < LAT; s++) begin
        stg_tag[s] <= '0;
        stg_res[s] <= '0;
      end
    end else if (bus.flush) begin
      stg_valid <= '0;
    end else if (advance) begin
      stg_valid[0] <= xfer;
      stg_tag[0]   <= grant;
      stg_res[0]   <= sum;
      for (int s = 1; s < LAT; s++) begin
        stg_valid[s] <= stg_valid[s-1];
        stg_tag[s]   <= stg_tag[s-1];
        stg_res[s]   <= stg_res[s-1];
      end
      if (xfer) ptr <= ptr_next;
    end
  end

  assign bus.rsp_valid = stg_valid[LAT-1];
  assign bus.rsp_data  = stg_res[LAT-1][WIDTH-1:0];
  assign bus.rsp_carry = stg_res[LAT-1][WIDTH];
  assign bus.rsp_tag   = stg_tag[LAT-1];
  assign bus.busy      = |stg_valid;

endmodule

// File: tb/tb_bram_adder_arbiter.sv
// Bench for bram_adder_arbiter: directed scenarios plus a randomized run checked
// against a slot-list reference model of the shared adder pipe.
module tb_bram_adder_arbiter;
  localparam int WIDTH = 4;
  localparam int N_REQ = 4;
  localparam int TAG_W = 2;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bram_adder_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TAG_W(TAG_W)) bus ();

  bram_adder_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TAG_W(TAG_W), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit v;
    int tag;
    int data;
    int carry;
  } slot_t;

  slot_t pipe[$];
  int    m_ptr;

  function automatic void model_reset();
    slot_t e;
    e = '{v: 1'b0, tag: 0, data: 0, carry: 0};
    pipe.delete();
    for (int i = 0; i < LAT; i++) pipe.push_back(e);
    m_ptr = 0;
  endfunction

  function automatic bit model_adv();
    return !pipe[LAT-1].v || bus.rsp_ready;
  endfunction

  function automatic bit model_busy();
    bit b = 1'b0;
    foreach (pipe[i]) b |= pipe[i].v;
    return b;
  endfunction

  function automatic int model_grant();
    if (!model_adv() || bus.flush) return -1;
    for (int i = 0; i < N_REQ; i++) begin
      int r = (m_ptr + i) % N_REQ;
      if (bus.req_valid[r]) return r;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] exp_ready();
    logic [N_REQ-1:0] r = '0;
    int g = model_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic void model_edge();
    int    g = model_grant();
    int    s;
    slot_t e;
    if (bus.flush) begin
      foreach (pipe[i]) pipe[i].v = 1'b0;
    end else if (model_adv()) begin
      e = '{v: (g >= 0), tag: 0, data: 0, carry: 0};
      if (g >= 0) begin
        s = int'(bus.req_a[g*WIDTH +: WIDTH]) + int'(bus.req_b[g*WIDTH +: WIDTH]) + 1;
        e.tag   = g;
        e.data  = s % (1 << WIDTH);
        e.carry = s >> WIDTH;
        m_ptr   = (g + 1) % N_REQ;
      end
      void'(pipe.pop_back());
      pipe.push_front(e);
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int r, input int a, input int b);
    bus.req_a[r*WIDTH +: WIDTH] = WIDTH'(a);
    bus.req_b[r*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    model_reset();
    #3;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    total++; if (bus.rsp_data !== 4'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
    total++; if (bus.rsp_carry !== 1'b0) begin bad++; $display("FAIL reset_rsp_carry got=%b exp=0", bus.rsp_carry); end
    total++; if (bus.rsp_tag !== 2'd0) begin bad++; $display("FAIL reset_rsp_tag got=%0d exp=0", bus.rsp_tag); end
    repeat (2) @(posedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    for (int r = 0; r < N_REQ; r++) set_ops(r, r + 1, 2 * r + 3);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = (c < 6) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (c < 6) begin
        total++;
        if (bus.req_ready !== 4'(1 << (c % 4))) begin
          bad++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << (c % 4)));
        end
      end
      if (c >= 2) begin
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 2'((c - 2) % 4)) begin
          bad++; $display("FAIL rr_tag cyc=%0d got=%b/%0d exp=1/%0d", c, bus.rsp_valid, bus.rsp_tag, (c - 2) % 4);
        end
        total++;
        if (bus.rsp_data !== 4'(pipe[LAT-1].data) || bus.rsp_carry !== 1'(pipe[LAT-1].carry)) begin
          bad++; $display("FAIL rr_data cyc=%0d got=%h/%b exp=%h/%0d", c, bus.rsp_data, bus.rsp_carry, pipe[LAT-1].data, pipe[LAT-1].carry);
        end
      end
      tick();
    end
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_ops(2, 3, 4);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready0 got=%b exp=0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready1 got=%b exp=0000", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", bus.rsp_valid); end
    tick();
    @(negedge clk);
    total++;
    if ({bus.rsp_valid, bus.rsp_carry, bus.rsp_data, bus.rsp_tag} !== {1'b1, 1'b0, 4'd8, 2'd2}) begin
      bad++; $display("FAIL single_rsp got=v%b c%b d%h t%0d exp=v1 c0 d8 t2", bus.rsp_valid, bus.rsp_carry, bus.rsp_data, bus.rsp_tag);
    end
    tick();
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_done got=v%b b%b exp=v0 b0", bus.rsp_valid, bus.busy); end
    tick();
  endtask

  task automatic test_wrap();
    logic [4:0] exp_cd [3];
    logic [1:0] exp_tag [3];
    exp_cd[0] = {1'b1, 4'hF}; exp_tag[0] = 2'd0;
    exp_cd[1] = {1'b1, 4'h0}; exp_tag[1] = 2'd1;
    exp_cd[2] = {1'b0, 4'h1}; exp_tag[2] = 2'd2;
    set_ops(0, 15, 15);
    set_ops(1, 15, 0);
    set_ops(2, 0, 0);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = (c < 3) ? 4'(1 << c) : 4'b0000;
      @(negedge clk);
      if (c >= 2) begin
        total++;
        if ({bus.rsp_valid, bus.rsp_carry, bus.rsp_data, bus.rsp_tag} !== {1'b1, exp_cd[c-2], exp_tag[c-2]}) begin
          bad++; $display("FAIL wrap_rsp%0d got=v%b c%b d%h t%0d exp=v1 c%b d%h t%0d", c - 2, bus.rsp_valid,
                          bus.rsp_carry, bus.rsp_data, bus.rsp_tag, exp_cd[c-2][4], exp_cd[c-2][3:0], exp_tag[c-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int n_rsp = 0;
    for (int r = 0; r < N_REQ; r++) set_ops(r, 5 + r, 9 - r);
    for (int c = 0; c < 10; c++) begin
      bus.rsp_ready = !(c >= 2 && c <= 4);
      bus.req_valid = (c < 7) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        total++;
        if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1) begin
          bad++; $display("FAIL bp_stall cyc=%0d got=ready%b v%b exp=ready0000 v1", c, bus.req_ready, bus.rsp_valid);
        end
      end else begin
        total++;
        if (bus.req_ready !== exp_ready()) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, exp_ready()); end
      end
      total++;
      if (bus.rsp_valid !== pipe[LAT-1].v ||
          (pipe[LAT-1].v && {bus.rsp_carry, bus.rsp_data, bus.rsp_tag} !==
           {1'(pipe[LAT-1].carry), 4'(pipe[LAT-1].data), 2'(pipe[LAT-1].tag)})) begin
        bad++; $display("FAIL bp_rsp cyc=%0d got=v%b c%b d%h t%0d exp=v%b c%0d d%h t%0d", c, bus.rsp_valid, bus.rsp_carry,
                        bus.rsp_data, bus.rsp_tag, pipe[LAT-1].v, pipe[LAT-1].carry, pipe[LAT-1].data, pipe[LAT-1].tag);
      end
      if ((exp_ready() & bus.req_valid) != '0) n_acc++;
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready) n_rsp++;
      tick();
    end
    total++; if (n_rsp != n_acc) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", n_rsp, n_acc); end
  endtask

  task automatic test_flush();
    bus.rsp_ready = 1'b1;
    set_ops(1, 2, 2);
    set_ops(2, 6, 1);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    tick();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    tick();
    bus.req_valid = 4'b1111;
    bus.flush = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL flush_ready got=%b exp=0000", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL flush_inflight got=v%b b%b exp=v1 b1", bus.rsp_valid, bus.busy); end
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL flush_clear got=v%b b%b exp=v0 b0", bus.rsp_valid, bus.busy); end
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL flush_ptr got=%b exp=1000", bus.req_ready); end
    bus.req_valid = 4'b0000;
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_drop cyc=%0d got=%b exp=0", c, bus.rsp_valid); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL areset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL areset_ready got=%b exp=0000", bus.req_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL areset_first got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    for (int c = 0; c < LAT + 1; c++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== pipe[LAT-1].v || (pipe[LAT-1].v && bus.rsp_tag !== 2'(pipe[LAT-1].tag))) begin
        bad++; $display("FAIL areset_after cyc=%0d got=v%b t%0d exp=v%b t%0d", c, bus.rsp_valid, bus.rsp_tag, pipe[LAT-1].v, pipe[LAT-1].tag);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] held = '0;
    logic [N_REQ-1:0] er;
    logic [WIDTH-1:0] op_a [N_REQ];
    logic [WIDTH-1:0] op_b [N_REQ];
    for (int r = 0; r < N_REQ; r++) begin op_a[r] = '0; op_b[r] = '0; end
    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (held[r]) begin
          bus.req_valid[r] = ($urandom_range(3) != 0);
        end else begin
          bus.req_valid[r] = 1'($urandom_range(1));
          op_a[r] = WIDTH'($urandom_range((1 << WIDTH) - 1));
          op_b[r] = WIDTH'($urandom_range((1 << WIDTH) - 1));
        end
        set_ops(r, int'(op_a[r]), int'(op_b[r]));
      end
      bus.rsp_ready = ($urandom_range(3) != 0);
      bus.flush = ($urandom_range(19) == 0);
      @(negedge clk);
      er = exp_ready();
      total++; if (bus.req_ready !== er) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, er); end
      total++; if (bus.busy !== model_busy()) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, bus.busy, model_busy()); end
      total++;
      if (bus.rsp_valid !== pipe[LAT-1].v ||
          (pipe[LAT-1].v && {bus.rsp_carry, bus.rsp_data, bus.rsp_tag} !==
           {1'(pipe[LAT-1].carry), 4'(pipe[LAT-1].data), 2'(pipe[LAT-1].tag)})) begin
        bad++; $display("FAIL rnd_rsp cyc=%0d got=v%b c%b d%h t%0d exp=v%b c%0d d%h t%0d", c, bus.rsp_valid, bus.rsp_carry,
                        bus.rsp_data, bus.rsp_tag, pipe[LAT-1].v, pipe[LAT-1].carry, pipe[LAT-1].data, pipe[LAT-1].tag);
      end
      held = bus.req_valid & ~er;
      tick();
    end
    bus.flush = 1'b0;
    bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
